// File: rtl/teller_call.sv
// ---------------------------------------------------------------------------
// teller_call -- "now serving" caller for a three-teller bank queue.
//
// Tellers raise TELLER_REQ[i] when ready; each rising edge latches a pending
// flag. While the queue is non-empty, pending tellers are granted round-robin.
// Each grant advances the BCD ticket shown on a seven-segment display. A call
// ends in one of three ways:
//    - a customer breaks the exit beam (EXIT_SENSE rising edge);
//    - the queue empties (PCOUNT == 0), which abandons the call;
//    - the call times out after TIMEOUT_CYCLES, which is a no-show.
//
// Ports
//    CLK          system clock, rising edge
//    RESET        asynchronous reset, active low
//    TELLER_REQ   per-teller ready level
//    PCOUNT       queue occupancy
//    EXIT_SENSE   exit photocell level, 1 = beam broken
//    CALL_VALID   high while a customer is being called
//    CALL_TELLER  index of the called teller
//    TICKET       now-serving number, BCD 0..9
//    SERVE_7SEG   TICKET display {g,f,e,d,c,b,a}; blank until the first call
//    PENDING      per-teller pending-request flags
//    TIMEOUT      one-cycle pulse after a no-show
//
//  state | meaning
//  IDLE  | waiting for a pending teller and a non-empty queue
//  CALL  | customer called; waiting for exit, queue empty or timeout
// ---------------------------------------------------------------------------
module teller_call #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] TELLER_REQ,
    input  logic [2:0] PCOUNT,
    input  logic       EXIT_SENSE,
    output logic       CALL_VALID,
    output logic [1:0] CALL_TELLER,
    output logic [3:0] TICKET,
    output logic [6:0] SERVE_7SEG,
    output logic [2:0] PENDING,
    output logic       TIMEOUT
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALL = 1'b1
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] call_teller_q, call_teller_d;
    logic [1:0] last_q, last_d;
    logic [3:0] ticket_q, ticket_d;
    logic [6:0] seg_q, seg_d;
    logic [2:0] pending_q, pending_d;
    logic       timeout_q, timeout_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] req_prev_q, req_prev_d;
    logic       exit_prev_q, exit_prev_d;

    logic [2:0] req_rise;
    logic       exit_rise;
    logic [2:0] call_mask;
    logic [1:0] start;
    logic [1:0] grant;
    logic       grant_found;
    logic [2:0] idx;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    always_comb begin
        req_rise  = TELLER_REQ & ~req_prev_q;
        exit_rise = EXIT_SENSE & ~exit_prev_q;

        // While calling, the called teller's own request edges are ignored.
        call_mask = 3'b000;
        if (state_q == ST_CALL) begin
            call_mask = 3'b001 << call_teller_q;
        end

        // Round-robin search starting just after the last granted teller.
        start       = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
        grant       = 2'd0;
        grant_found = 1'b0;
        idx         = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, start} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!grant_found && pending_q[idx[1:0]]) begin
                grant       = idx[1:0];
                grant_found = 1'b1;
            end
        end

        state_d       = state_q;
        call_teller_d = call_teller_q;
        last_d        = last_q;
        ticket_d      = ticket_q;
        seg_d         = seg_q;
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
        req_prev_d    = TELLER_REQ;
        exit_prev_d   = EXIT_SENSE;
        pending_d     = pending_q | (req_rise & ~call_mask);

        case (state_q)
            ST_IDLE: begin
                if (pending_q != 3'b000 && PCOUNT != 3'd0) begin
                    state_d       = ST_CALL;
                    call_teller_d = grant;
                    last_d        = grant;
                    ticket_d      = (ticket_q == 4'd9) ? 4'd0 : ticket_q + 4'd1;
                    seg_d         = seg_encode(ticket_d);
                    cnt_d         = 8'd0;
                end
            end
            ST_CALL: begin
                // Exit wins over both queue-empty abort and timeout.
                if (exit_rise) begin
                    pending_d = pending_d & ~call_mask;
                    state_d   = ST_IDLE;
                end else if (PCOUNT == 3'd0) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    pending_d = pending_d & ~call_mask;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q       <= ST_IDLE;
            call_teller_q <= 2'd0;
            last_q        <= 2'd2;
            ticket_q      <= 4'd0;
            seg_q         <= 7'b0000000;
            pending_q     <= 3'b000;
            timeout_q     <= 1'b0;
            cnt_q         <= 8'd0;
            req_prev_q    <= 3'b000;
            exit_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            call_teller_q <= call_teller_d;
            last_q        <= last_d;
            ticket_q      <= ticket_d;
            seg_q         <= seg_d;
            pending_q     <= pending_d;
            timeout_q     <= timeout_d;
            cnt_q         <= cnt_d;
            req_prev_q    <= req_prev_d;
            exit_prev_q   <= exit_prev_d;
        end
    end

    assign CALL_VALID  = (state_q == ST_CALL);
    assign CALL_TELLER = call_teller_q;
    assign TICKET      = ticket_q;
    assign SERVE_7SEG  = seg_q;
    assign PENDING     = pending_q;
    assign TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_teller_call.sv
// ---------------------------------------------------------------------------
// tb_teller_call -- directed scenarios plus randomized traffic for
// teller_call, compared every cycle against a behavioural queue-caller model.
// ---------------------------------------------------------------------------
module tb_teller_call;

    localparam int TO_CYC = 16;

    logic       CLK;
    logic       RESET;
    logic [2:0] TELLER_REQ;
    logic [2:0] PCOUNT;
    logic       EXIT_SENSE;
    logic       CALL_VALID;
    logic [1:0] CALL_TELLER;
    logic [3:0] TICKET;
    logic [6:0] SERVE_7SEG;
    logic [2:0] PENDING;
    logic       TIMEOUT;

    int n_chk;
    int n_err;

    teller_call #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .TELLER_REQ (TELLER_REQ),
        .PCOUNT     (PCOUNT),
        .EXIT_SENSE (EXIT_SENSE),
        .CALL_VALID (CALL_VALID),
        .CALL_TELLER(CALL_TELLER),
        .TICKET     (TICKET),
        .SERVE_7SEG (SERVE_7SEG),
        .PENDING    (PENDING),
        .TIMEOUT    (TIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Seven-segment digits {g,f,e,d,c,b,a}.
    int seg_tbl [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

    // Behavioural model of the caller.
    bit calling;
    bit pend [3];
    int who;
    int ticket;
    int seg;
    bit to_pulse;
    int last;
    int age;
    bit req_old [3];
    bit exit_old;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pend_vec();
        return (pend[2] ? 4 : 0) + (pend[1] ? 2 : 0) + (pend[0] ? 1 : 0);
    endfunction

    task automatic model_reset();
        calling  = 0;
        who      = 0;
        ticket   = 0;
        seg      = 0;
        to_pulse = 0;
        last     = 2;
        age      = 0;
        exit_old = 0;
        for (int i = 0; i < 3; i++) begin
            pend[i]    = 0;
            req_old[i] = 0;
        end
    endtask

    task automatic model_step();
        bit was_pend [3];
        bit exit_new;
        bit any;
        for (int i = 0; i < 3; i++) was_pend[i] = pend[i];
        exit_new = EXIT_SENSE && !exit_old;
        to_pulse = 0;
        for (int i = 0; i < 3; i++) begin
            if (TELLER_REQ[i] && !req_old[i] && !(calling && i == who)) pend[i] = 1;
        end
        if (!calling) begin
            any = was_pend[0] || was_pend[1] || was_pend[2];
            if (any && PCOUNT != 0) begin
                for (int k = 1; k <= 3; k++) begin
                    if (!calling && was_pend[(last + k) % 3]) begin
                        who     = (last + k) % 3;
                        calling = 1;
                    end
                end
                last   = who;
                ticket = (ticket + 1) % 10;
                seg    = seg_tbl[ticket];
                age    = 0;
            end
        end else begin
            if (exit_new) begin
                pend[who] = 0;
                calling   = 0;
            end else if (PCOUNT == 0) begin
                calling = 0;
            end else if (age == TO_CYC - 1) begin
                pend[who] = 0;
                to_pulse  = 1;
                calling   = 0;
            end else begin
                age++;
            end
        end
        for (int i = 0; i < 3; i++) req_old[i] = TELLER_REQ[i];
        exit_old = EXIT_SENSE;
    endtask

    task automatic compare_all();
        chk("call_valid", int'(CALL_VALID), int'(calling));
        chk("pending", int'(PENDING), pend_vec());
        chk("timeout", int'(TIMEOUT), int'(to_pulse));
        chk("ticket", int'(TICKET), ticket);
        chk("serve_7seg", int'(SERVE_7SEG), seg);
        if (calling) chk("call_teller", int'(CALL_TELLER), who);
    endtask

    // One clock: model follows the DUT's edge, outputs sampled 1 ns later.
    task automatic cyc();
        @(posedge CLK);
        if (!RESET) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        RESET      = 1'b0;
        TELLER_REQ = 3'b000;
        PCOUNT     = 3'd0;
        EXIT_SENSE = 1'b0;
        #1;
        model_reset();
        cyc();
        cyc();
        RESET = 1'b1;
    endtask

    task automatic wait_call(input int budget);
        int n;
        n = 0;
        while (!CALL_VALID && n < budget) begin
            cyc();
            n++;
        end
        if (!CALL_VALID) chk("wait_call_expired", 0, 1);
    endtask

    task automatic serve_one(input int t);
        TELLER_REQ = 3'(1 << t);
        wait_call(8);
        TELLER_REQ = 3'b000;
        EXIT_SENSE = 1'b1;
        cyc();
        EXIT_SENSE = 1'b0;
        cyc();
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        RESET = 1'b0;
        do_reset();

        // reset state
        chk("rst_seg", int'(SERVE_7SEG), 0);
        chk("rst_pending", int'(PENDING), 0);

        // single call, exit completes it
        PCOUNT = 3'd3;
        cyc();
        TELLER_REQ = 3'b001;
        cyc();
        chk("d1_pending", int'(PENDING), 1);
        chk("d1_not_yet", int'(CALL_VALID), 0);
        cyc();
        chk("d1_valid", int'(CALL_VALID), 1);
        chk("d1_teller", int'(CALL_TELLER), 0);
        chk("d1_ticket", int'(TICKET), 1);
        chk("d1_seg", int'(SERVE_7SEG), 'h06);
        EXIT_SENSE = 1'b1;
        cyc();
        chk("d1_exit_idle", int'(CALL_VALID), 0);
        chk("d1_exit_pend", int'(PENDING), 0);
        EXIT_SENSE = 1'b0;
        TELLER_REQ = 3'b000;
        cyc();

        // three simultaneous requests, round-robin 0,1,2
        do_reset();
        PCOUNT     = 3'd2;
        TELLER_REQ = 3'b111;
        for (int g = 0; g < 3; g++) begin
            wait_call(8);
            chk("rr_teller", int'(CALL_TELLER), g);
            chk("rr_ticket", int'(TICKET), g + 1);
            EXIT_SENSE = 1'b1;
            cyc();
            EXIT_SENSE = 1'b0;
            cyc();
        end
        TELLER_REQ = 3'b000;
        cyc();

        // no-show timeout on teller 1
        do_reset();
        PCOUNT     = 3'd1;
        TELLER_REQ = 3'b010;
        wait_call(8);
        chk("to_teller", int'(CALL_TELLER), 1);
        for (int i = 1; i < TO_CYC; i++) begin
            cyc();
            chk("to_early", int'(TIMEOUT), 0);
        end
        cyc();
        chk("to_pulse", int'(TIMEOUT), 1);
        chk("to_idle", int'(CALL_VALID), 0);
        chk("to_pend", int'(PENDING), 0);
        cyc();
        chk("to_one_cycle", int'(TIMEOUT), 0);

        // exit coincident with the last count: exit wins
        TELLER_REQ = 3'b000;
        cyc();
        TELLER_REQ = 3'b010;
        wait_call(8);
        for (int i = 1; i < TO_CYC; i++) cyc();
        EXIT_SENSE = 1'b1;
        cyc();
        chk("co_no_timeout", int'(TIMEOUT), 0);
        chk("co_idle", int'(CALL_VALID), 0);
        chk("co_pend", int'(PENDING), 0);
        EXIT_SENSE = 1'b0;
        TELLER_REQ = 3'b000;
        cyc();
        chk("co_no_late_pulse", int'(TIMEOUT), 0);

        // ticket wrap after ten completed calls
        do_reset();
        PCOUNT = 3'd4;
        for (int i = 0; i < 10; i++) serve_one(i % 3);
        chk("wrap_ticket", int'(TICKET), 0);
        chk("wrap_seg", int'(SERVE_7SEG), 'h3F);

        // empty queue holds off the call; emptying mid-call aborts it
        do_reset();
        PCOUNT     = 3'd0;
        TELLER_REQ = 3'b010;
        for (int i = 0; i < 4; i++) cyc();
        chk("pc0_idle", int'(CALL_VALID), 0);
        chk("pc0_pend", int'(PENDING), 2);
        PCOUNT = 3'd1;
        cyc();
        chk("pc1_call", int'(CALL_VALID), 1);
        PCOUNT = 3'd0;
        cyc();
        chk("abort_idle", int'(CALL_VALID), 0);
        chk("abort_pend", int'(PENDING), 2);
        chk("abort_ticket", int'(TICKET), 1);
        chk("abort_no_to", int'(TIMEOUT), 0);
        PCOUNT = 3'd1;
        cyc();
        chk("recall", int'(CALL_VALID), 1);

        // asynchronous reset in the middle of a call
        #2;
        RESET = 1'b0;
        #1;
        model_reset();
        chk("arst_valid", int'(CALL_VALID), 0);
        chk("arst_teller", int'(CALL_TELLER), 0);
        chk("arst_ticket", int'(TICKET), 0);
        chk("arst_seg", int'(SERVE_7SEG), 0);
        chk("arst_pend", int'(PENDING), 0);
        chk("arst_to", int'(TIMEOUT), 0);
        cyc();
        cyc();
        RESET      = 1'b1;
        TELLER_REQ = 3'b000;
        PCOUNT     = 3'd0;
        cyc();

        // randomized traffic: frequent exits, then rare exits to reach timeouts
        for (int ph = 0; ph < 2; ph++) begin
            for (int n = 0; n < 3000; n++) begin
                for (int b = 0; b < 3; b++) begin
                    if ($urandom_range(5, 0) == 0) TELLER_REQ[b] = ~TELLER_REQ[b];
                end
                if ($urandom_range(ph == 0 ? 7 : 45, 0) == 0) EXIT_SENSE = ~EXIT_SENSE;
                if ($urandom_range(19, 0) == 0) PCOUNT = 3'd0;
                else if ($urandom_range(3, 0) == 0) PCOUNT = 3'($urandom_range(7, 1));
                cyc();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
